demux16_2: RTL and testbench

Registered 1-to-4 demultiplexer for a narrow data word. A data word `D` is steered to exactly one of four outputs `Y0`–`Y3`, selected by the 2-bit select `S`. The three non-selected outputs are driven to zero. It is a small routing primitive between a single producer and four consumer lanes. All outputs are registered on a single clock with a synchronous, active-high reset.

---
 rtl/demux16_2_if.sv | 35 +++
 rtl/demux16_2.sv | 46 ++++
 tb/tb_demux16_2.sv | 110 +++++++++++
 3 files changed

// File: rtl/demux16_2_if.sv
// rtl/demux16_2_if.sv - routing bus between one producer and the demux16_2 lanes
//
// Purpose: groups the demultiplexer's enable, data, select and lane outputs.
// Signals:
//    en      - update enable (producer -> demux)
//    D       - data word to route, WIDTH bits (producer -> demux)
//    S       - 2-bit lane select (producer -> demux)
//    Y0..Y3  - registered lane data, WIDTH bits each (demux -> consumers)
//    sel_oh  - registered one-hot copy of the select (demux -> consumers)
// Modports:
//    master  - producer/observer side
//    slave   - demux side

interface demux16_2_if #(
   parameter int WIDTH = 3
);
   logic             en;
   logic [WIDTH-1:0] D;
   logic [1:0]       S;
   logic [WIDTH-1:0] Y0;
   logic [WIDTH-1:0] Y1;
   logic [WIDTH-1:0] Y2;
   logic [WIDTH-1:0] Y3;
   logic [3:0]       sel_oh;

   modport master (
      output en, D, S,
      input  Y0, Y1, Y2, Y3, sel_oh
   );

   modport slave (
      input  en, D, S,
      output Y0, Y1, Y2, Y3, sel_oh
   );
endinterface

// File: rtl/demux16_2.sv
// rtl/demux16_2.sv - registered 1-to-4 demultiplexer
//
// Purpose: steers data word D onto exactly one of four lanes selected by S;
// the other three lanes are driven to zero. All outputs are registered.
// Ports:
//    clk  - rising-edge clock
//    rst  - synchronous active-high reset (clears all lanes and sel_oh)
//    bus  - demux16_2_if slave modport: en, D, S in; Y0..Y3, sel_oh out
// Edge priority: rst, then en, then hold.

module demux16_2 #(
   parameter int WIDTH = 3
) (
   input  logic         clk,
   input  logic         rst,
   demux16_2_if.slave   bus
);

   logic [WIDTH-1:0] y_next [4];
   logic [3:0]       oh_next;

   // Unselected lanes are forced to zero so a lane switch leaves no residue.
   always_comb begin
      oh_next = 4'b0001 << bus.S;
      for (int k = 0; k < 4; k++) begin
         y_next[k] = (bus.S == 2'(k)) ? bus.D : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.Y0     <= '0;
         bus.Y1     <= '0;
         bus.Y2     <= '0;
         bus.Y3     <= '0;
         bus.sel_oh <= 4'b0000;
      end else if (bus.en) begin
         bus.Y0     <= y_next[0];
         bus.Y1     <= y_next[1];
         bus.Y2     <= y_next[2];
         bus.Y3     <= y_next[3];
         bus.sel_oh <= oh_next;
      end
   end

endmodule

// File: tb/tb_demux16_2.sv
// tb/tb_demux16_2.sv - self-checking bench for demux16_2 (WIDTH 3 and WIDTH 8)

module tb_demux16_2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   demux16_2_if #(.WIDTH(3)) b3 ();
   demux16_2_if #(.WIDTH(8)) b8 ();

   demux16_2 #(.WIDTH(3)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));
   demux16_2 #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(b8.slave));

   int total = 0;
   int bad   = 0;

   // reference model: lane contents and last-written lane
   logic [2:0] m3 [4];
   logic [7:0] m8 [4];
   logic [3:0] moh;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic e, input logic [2:0] d3,
                       input logic [7:0] d8, input logic [1:0] s);
      rst   = r;
      b3.en = e; b3.D = d3; b3.S = s;
      b8.en = e; b8.D = d8; b8.S = s;
      @(posedge clk);
      if (r) begin
         for (int k = 0; k < 4; k++) begin
            m3[k] = '0;
            m8[k] = '0;
         end
         moh = 4'b0000;
      end else if (e) begin
         for (int k = 0; k < 4; k++) begin
            m3[k] = (k == int'(s)) ? d3 : 3'd0;
            m8[k] = (k == int'(s)) ? d8 : 8'd0;
         end
         moh = 4'b0001 << s;
      end
      #1;
      chk("y0_w3", 8'(b3.Y0), 8'(m3[0]));
      chk("y1_w3", 8'(b3.Y1), 8'(m3[1]));
      chk("y2_w3", 8'(b3.Y2), 8'(m3[2]));
      chk("y3_w3", 8'(b3.Y3), 8'(m3[3]));
      chk("oh_w3", 8'(b3.sel_oh), 8'(moh));
      chk("y0_w8", b8.Y0, m8[0]);
      chk("y1_w8", b8.Y1, m8[1]);
      chk("y2_w8", b8.Y2, m8[2]);
      chk("y3_w8", b8.Y3, m8[3]);
      chk("oh_w8", 8'(b8.sel_oh), 8'(moh));
   endtask

   initial begin
      rst = 1'b1;
      b3.en = 1'b0; b3.D = '0; b3.S = '0;
      b8.en = 1'b0; b8.D = '0; b8.S = '0;
      @(negedge clk);

      // reset with active-looking inputs
      step(1, 1, 3'b111, 8'hFF, 2'b10);
      step(1, 1, 3'b111, 8'hFF, 2'b10);

      // select sweep
      step(0, 1, 3'b111, 8'h3C, 2'b00);
      step(0, 1, 3'b111, 8'h3C, 2'b01);
      step(0, 1, 3'b111, 8'h3C, 2'b10);
      step(0, 1, 3'b111, 8'h3C, 2'b11);

      // data pattern on lane 1
      step(0, 1, 3'b000, 8'h00, 2'b01);
      step(0, 1, 3'b101, 8'h5A, 2'b01);
      step(0, 1, 3'b010, 8'h81, 2'b01);

      // hold
      step(0, 1, 3'b110, 8'hC3, 2'b10);
      step(0, 0, 3'b001, 8'h11, 2'b00);
      step(0, 0, 3'b001, 8'h22, 2'b00);
      step(0, 0, 3'b001, 8'h33, 2'b00);

      // reset priority over enable, then first post-reset update
      step(0, 1, 3'b111, 8'hEE, 2'b11);
      step(1, 1, 3'b111, 8'hEE, 2'b00);
      step(0, 1, 3'b111, 8'hEE, 2'b00);

      // width check
      step(0, 1, 3'b011, 8'hA5, 2'b11);

      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
              3'($urandom), 8'($urandom), 2'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
